load_store_unit: RTL and testbench

//  Sits between the execute stage and the word-addressed data memory. It turns RV32I loads and

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 41 ++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, write-enable codes, FSM states.
// Pure declarations; no timing or backpressure of its own.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_B    = 4'b0001;
  localparam logic [3:0] WE_H    = 4'b0011;
  localparam logic [3:0] WE_W    = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_H || f3 == F3_HU) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] we_code(input logic [1:0] size);
    case (size)
      2'b00:   return WE_B;
      2'b01:   return WE_H;
      default: return WE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extract with sign/zero extension, store-lane merge.
// Zero latency; no flow control.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   off,
  input  logic [W-1:0] rword,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] ldata,
  output logic [W-1:0] mdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rword[{off, 3'b000} +: 8];
    half_v = rword[{off[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    ldata = {{(W-8){byte_v[7]}}, byte_v};
      F3_H:    ldata = {{(W-16){half_v[15]}}, half_v};
      F3_W:    ldata = rword;
      F3_BU:   ldata = {{(W-8){1'b0}}, byte_v};
      F3_HU:   ldata = {{(W-16){1'b0}}, half_v};
      default: ldata = '0;
    endcase

    // Read-modify-write image: the old word with only the addressed lane replaced.
    mdata = rword;
    case (funct3[1:0])
      2'b00:   mdata[{off, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   mdata[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: mdata = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed memory; RMW for offset byte/half stores.
// Latency 1 (error) / 2 (load, aligned store) / 3 (RMW); response held until resp_ready. Option: LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        we,
  output logic              re,
  output logic [31:0]       dmem_in,
  input  logic [31:0]       dmem_out
);

  localparam int BA_W = ADDR_W + 2;

  state_t            state, state_n;
  logic [2:0]        f3_q;
  logic [BA_W-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic              pend_q;
  logic [XLEN-1:0]   rdata_q;
  logic              req_oob;
  logic              req_err;
  logic              accept;
  logic [XLEN-1:0]   ldata;
  logic [XLEN-1:0]   mdata;

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_oob = |req_addr[XLEN-1:BA_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[XLEN-1:BA_W];
  assign req_oob        = 1'b0;
`endif

  assign req_err   = f3_illegal(req_funct3) || misaligned(req_funct3, req_addr[1:0]) || req_oob;
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  lsu_align #(.W(XLEN)) u_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .rword  (dmem_out),
    .wdata  (wdata_q),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    re      = 1'b0;
    we      = WE_NONE;
    dmem_in = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                    state_n = S_RESP;
          else if (!req_store)            state_n = S_RD;
          else if (req_addr[1:0] == 2'b0) state_n = S_WR;
          else                            state_n = S_RMW_RD;
        end
      end
      S_RD: begin
        re      = 1'b1;
        state_n = S_RESP;
      end
      S_WR: begin
        we      = we_code(f3_q[1:0]);
        dmem_in = wdata_q;
        state_n = S_RESP;
      end
      S_RMW_RD: begin
        re      = 1'b1;
        state_n = S_RMW_WR;
      end
      S_RMW_WR: begin
        we      = WE_W;
        dmem_in = mdata;
        state_n = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Read data is live on dmem_out only in the first RESP cycle; capture it there so
  // the response stays stable however long the core stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q <= (state == S_RD);
      if (accept) begin
        f3_q    <= req_funct3;
        addr_q  <= req_addr[BA_W-1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (pend_q) rdata_q <= ldata;
    end
  end

  assign dmem_addr  = addr_q[BA_W-1:2];
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = !resp_valid ? '0 : (pend_q ? ldata : rdata_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level memory model.
// Covers literal load/store/error cases, response stall, mid-RMW reset and address wrap/bounds.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  dmem_addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dmem_in, dmem_out;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dmem_addr(dmem_addr), .we(we), .re(re),
    .dmem_in(dmem_in), .dmem_out(dmem_out)
  );

  // Physical memory honouring the we byte codes; read data is garbage unless re was high.
  logic [31:0] pmem [0:1023];
  logic [31:0] gmem [0:1023];

  always @(posedge clk) begin
    if (we[0]) pmem[dmem_addr][7:0]   <= dmem_in[7:0];
    if (we[1]) pmem[dmem_addr][15:8]  <= dmem_in[15:8];
    if (we[2]) pmem[dmem_addr][23:16] <= dmem_in[23:16];
    if (we[3]) pmem[dmem_addr][31:24] <= dmem_in[31:24];
    dmem_out <= re ? pmem[dmem_addr] : $urandom;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  bit          exp_active = 1'b0;
  bit          exp_err;
  logic [31:0] exp_rdata;
  int          cyc = 0, acc_cyc = 0;
  int          nre = 0, nwe = 0, re_rel = 0, we_rel = 0;
  logic [3:0]  last_we;
  logic [31:0] last_din, last_rdata;
  logic [9:0]  last_raddr;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare: response contents against the model, plus access bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      chk("re_we_exclusive", {31'b0, re && (we != 4'b0)}, 32'd0);
      if (re) begin
        nre++;
        re_rel     = cyc - acc_cyc + 1;
        last_raddr = dmem_addr;
      end
      if (we != 4'b0) begin
        nwe++;
        we_rel   = cyc - acc_cyc + 1;
        last_we  = we;
        last_din = dmem_in;
      end
      if (exp_active && resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
      end else if (!exp_active) begin
        chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
      end
    end
  end

  // Transaction-level reference: outcome, timing and memory effect of one request.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat, output int ere, output int ewe,
                       output int ere_at, output int ewe_at);
    int          o, bsh, hsh;
    logic [9:0]  wi;
    logic [31:0] w, b, h;
    bit          illegal, mis, oob;
    o   = int'(a[1:0]);
    bsh = 8 * o;
    hsh = 16 * (o / 2);
    wi  = a[11:2];
    w   = gmem[wi];
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    mis     = ((f3 == 3'd1 || f3 == 3'd5) && (o % 2 == 1)) || (f3 == 3'd2 && o != 0);
    oob     = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    oob = (a[31:12] != 20'd0);
`endif
    err = illegal || mis || oob;
    rd = 32'd0; ere = 0; ewe = 0; ere_at = 0; ewe_at = 0; lat = 1;
    if (!err) begin
      if (!st) begin
        b = (w >> bsh) & 32'hFF;
        h = (w >> hsh) & 32'hFFFF;
        case (f3)
          3'd0: rd = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
          3'd1: rd = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
          3'd2: rd = w;
          3'd4: rd = b;
          default: rd = h;
        endcase
        lat = 2; ere = 1; ere_at = 1;
      end else begin
        case (f3)
          3'd0:    gmem[wi] = (w & ~(32'hFF << bsh))   | ((wd & 32'hFF) << bsh);
          3'd1:    gmem[wi] = (w & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
          default: gmem[wi] = wd;
        endcase
        ewe = 1;
        if (o == 0) begin lat = 2; ewe_at = 1; end
        else begin lat = 3; ere = 1; ere_at = 1; ewe_at = 2; end
      end
    end
  endtask

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    bit          e;
    logic [31:0] r;
    int          lat, ere, ewe, ere_at, ewe_at, cnt;
    model(st, f3, a, wd, e, r, lat, ere, ewe, ere_at, ewe_at);
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc; nre = 0; nwe = 0; re_rel = 0; we_rel = 0;
    exp_rdata = r; exp_err = e; exp_active = 1'b1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    req_store  = 1'($urandom);
    cnt = 1;
    @(negedge clk);
    while (!resp_valid && cnt < 8) begin
      cnt++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
      finish_up();
    end
    chk("latency", 32'(cnt), 32'(lat));
    last_rdata = resp_rdata;
    last_err   = resp_err;
    repeat (hold) begin
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("n_re", 32'(nre), 32'(ere));
    chk("n_we", 32'(nwe), 32'(ewe));
    if (ere != 0) chk("re_cycle", 32'(re_rel), 32'(ere_at));
    if (ewe != 0) chk("we_cycle", 32'(we_rel), 32'(ewe_at));
    chk("mem_word", pmem[a[11:2]], gmem[a[11:2]]);
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    pmem[idx] = v;
    gmem[idx] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_err++;
    finish_up();
  end

  initial begin
    logic [2:0]  st_f3 [6];
    logic [31:0] a;
    bit          st;
    logic [2:0]  f3;
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_we", {28'b0, we}, 32'd0);
    chk("rst_re", {31'b0, re}, 32'd0);
    chk("rst_dmem_addr", {22'b0, dmem_addr}, 32'd0);
    chk("rst_dmem_in", dmem_in, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_word(5, 32'h1131_1762);
    do_txn(1'b0, 3'd0, 32'h16, 32'd0, 0);  chk("lit_lb_16", last_rdata, 32'h0000_0031);
    do_txn(1'b0, 3'd4, 32'h17, 32'd0, 0);  chk("lit_lbu_17", last_rdata, 32'h0000_0011);
    set_word(5, 32'h1981_6562);
    do_txn(1'b0, 3'd1, 32'h14, 32'd0, 0);  chk("lit_lh_14", last_rdata, 32'h0000_6562);
    do_txn(1'b0, 3'd1, 32'h16, 32'd0, 0);  chk("lit_lh_16", last_rdata, 32'h0000_1981);
    do_txn(1'b0, 3'd0, 32'h14, 32'd0, 0);  chk("lit_lb_14", last_rdata, 32'h0000_0062);
    set_word(5, 32'h8000_FF80);
    do_txn(1'b0, 3'd0, 32'h14, 32'd0, 0);  chk("lit_lb_neg", last_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 3'd5, 32'h16, 32'd0, 0);  chk("lit_lhu_16", last_rdata, 32'h0000_8000);

    set_word(2, 32'h1700_3972);
    do_txn(1'b1, 3'd0, 32'h09, 32'hAB, 0);
    chk("lit_rmw_we", {28'b0, last_we}, 32'h0000_000F);
    chk("lit_rmw_din", last_din, 32'h1700_AB72);
    do_txn(1'b1, 3'd1, 32'h08, 32'hBEEF, 0);
    chk("lit_sh_we", {28'b0, last_we}, 32'h0000_0003);
    chk("lit_sh_mem", pmem[2], 32'h1700_BEEF);

    do_txn(1'b0, 3'd2, 32'h0A, 32'd0, 0);
    chk("lit_lw_mis_err", {31'b0, last_err}, 32'd1);
    chk("lit_lw_mis_rdata", last_rdata, 32'd0);
    do_txn(1'b1, 3'd1, 32'h03, 32'h1234, 0);
    chk("lit_sh_mis_err", {31'b0, last_err}, 32'd1);
    do_txn(1'b0, 3'd3, 32'h20, 32'd0, 0);
    chk("lit_f3_011_err", {31'b0, last_err}, 32'd1);

    do_txn(1'b0, 3'd2, 32'h14, 32'd0, 3);

    // Reset while the RMW read is in flight: no write, no response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h09; req_wdata = 32'hCD;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_we", {28'b0, we}, 32'd0);
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_mem", pmem[2], 32'h1700_BEEF);

    do_txn(1'b0, 3'd2, 32'h1000, 32'd0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("lit_oob_err", {31'b0, last_err}, 32'd1);
`else
    chk("lit_wrap_err", {31'b0, last_err}, 32'd0);
    chk("lit_wrap_addr", {22'b0, last_raddr}, 32'd0);
`endif

    for (int i = 0; i < 250; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      a  = {20'd0, 6'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
      do_txn(st, f3, a, $urandom, $urandom_range(0, 3));
    end

    finish_up();
  end

endmodule
